// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// M-op funct3 encodings, FSM states and divide special-case helpers.
package muldiv_ctrl_pkg;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Result for divide-by-zero or signed overflow; is_rem picks the remainder form.
    function automatic logic [31:0] div_special(
        input logic        is_rem,
        input logic        div0,
        input logic [31:0] dividend
    );
        if (div0)
            return is_rem ? dividend : 32'hFFFF_FFFF;
        return is_rem ? 32'h0 : INT_MIN;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_multiplier.sv
// Combinational 32x32 multiplier covering MUL, MULH, MULHSU and MULHU.
// Operands are sign- or zero-extended to 64 bits; the low 64 product bits are exact.
module multiplier (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        is_mul,
    input  logic        is_mulh,
    input  logic        is_mulhsu,
    input  logic        is_mulhu,
    output logic [31:0] product_o
);

    logic        a_sgn;
    logic        b_sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    assign a_sgn = (is_mulh | is_mulhsu) & a_i[31];
    assign b_sgn = is_mulh & b_i[31];
    assign a_ext = {{32{a_sgn}}, a_i};
    assign b_ext = {{32{b_sgn}}, b_i};
    assign prod  = a_ext * b_ext;

    always_comb begin
        product_o = prod[31:0];
        unique case (1'b1)
            is_mul:    product_o = prod[31:0];
            is_mulh:   product_o = prod[63:32];
            is_mulhsu: product_o = prod[63:32];
            is_mulhu:  product_o = prod[63:32];
            default:   product_o = prod[31:0];
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M execute sequencer: multicycle multiply hold plus radix-2 restoring divider.
// One operation in flight; tagged result returned over a valid/ready handshake.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    input  logic            flush_i,
    output logic            busy_o
);

    localparam int CNT_W = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    state_e           state;
    op_e              op_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  rem_q;
    logic             neg_q;
    logic             neg_r;
    logic [CNT_W-1:0] cnt;

    assign req_ready_o = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);

    logic is_mul, is_mulh, is_mulhsu, is_mulhu;
    logic [XLEN-1:0] product;

    assign is_mul    = (op_q == OP_MUL);
    assign is_mulh   = (op_q == OP_MULH);
    assign is_mulhsu = (op_q == OP_MULHSU);
    assign is_mulhu  = (op_q == OP_MULHU);

    multiplier u_mul (
        .a_i       (rs1_q),
        .b_i       (rs2_q),
        .is_mul    (is_mul),
        .is_mulh   (is_mulh),
        .is_mulhsu (is_mulhsu),
        .is_mulhu  (is_mulhu),
        .product_o (product)
    );

    logic            sgn_in;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;

    assign sgn_in = ~op_i[0];
    assign div0   = (rs2_i == '0);
    assign ovf    = sgn_in && (rs1_i == INT_MIN) && (rs2_i == '1);
    assign a_abs  = (sgn_in && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    assign b_abs  = (sgn_in && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

    // 33-bit accumulator keeps the trial subtraction free of overflow.
    logic [XLEN:0]   acc;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quot_nx;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] div_res;

    assign acc     = {rem_q, quot_q[XLEN-1]};
    assign trial   = acc - {1'b0, dvs_q};
    assign rem_nx  = trial[XLEN] ? acc[XLEN-1:0] : trial[XLEN-1:0];
    assign quot_nx = {quot_q[XLEN-2:0], ~trial[XLEN]};
    assign q_fix   = neg_q ? -quot_nx : quot_nx;
    assign r_fix   = neg_r ? -rem_nx : rem_nx;
    assign div_res = op_q[1] ? r_fix : q_fix;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            op_q         <= OP_MUL;
            rs1_q        <= '0;
            rs2_q        <= '0;
            quot_q       <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            cnt          <= '0;
            resp_valid_o <= 1'b0;
            result_o     <= '0;
            rd_o         <= '0;
        end else if (flush_i) begin
            state        <= ST_IDLE;
            resp_valid_o <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_q  <= op_e'(op_i);
                        rs1_q <= rs1_i;
                        rs2_q <= rs2_i;
                        rd_o  <= rd_i;
                        cnt   <= '0;
                        if (!op_i[2]) begin
                            state <= ST_MUL;
                        end else if (div0 || ovf) begin
                            result_o     <= div_special(op_i[1], div0, rs1_i);
                            resp_valid_o <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            quot_q <= a_abs;
                            dvs_q  <= b_abs;
                            rem_q  <= '0;
                            neg_q  <= sgn_in & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                            neg_r  <= sgn_in & rs1_i[XLEN-1];
                            state  <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt == MUL_LAST) begin
                        result_o     <= product;
                        resp_valid_o <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    quot_q <= quot_nx;
                    rem_q  <= rem_nx;
                    // Final iteration result goes straight through the sign fix.
                    if (cnt == DIV_LAST) begin
                        result_o     <= div_res;
                        resp_valid_o <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized check of muldiv_ctrl against an arithmetic RV32M reference model.
// Covers latency, backpressure, flush and mid-operation reset.
module tb_muldiv_ctrl;

    localparam int LAT = 1;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        flush;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(32), .MUL_LAT(LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .op_i         (op),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .rd_i         (rd),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .result_o     (result),
        .rd_o         (rd_out),
        .flush_i      (flush),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f < 3'd4) return LAT + 1;
        if (b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == MIN && b == 32'hFFFF_FFFF)
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input int stall);
        logic [31:0] exp;
        logic [31:0] held;
        int lat;
        exp = model(f, a, b);
        chk({tag, "/rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        op  = f;
        rs1 = a;
        rs2 = b;
        rd  = t;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        rd  = 5'($urandom);
        lat = 1;
        while (!resp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat(f, a, b)));
        chk({tag, "/res"}, result, exp);
        chk({tag, "/rd"}, 32'(rd_out), 32'(t));
        held = result;
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            op = 3'($urandom);
            @(posedge clk); #1;
            chk({tag, "/hold"}, result, held);
            chk({tag, "/hrd"}, 32'(rd_out), 32'(t));
            chk({tag, "/hrdy"}, 32'(req_ready), 32'd0);
            chk({tag, "/hval"}, 32'(resp_valid), 32'd1);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "/rel"}, 32'(resp_valid), 32'd0);
        chk({tag, "/idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        flush = 1'b0;
        op = 3'd0;
        rs1 = '0;
        rs2 = '0;
        rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_val", 32'(resp_valid), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_rd", 32'(rd_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd1);

        do_op("mul2x8", 3'd0, 32'd2, 32'd8, 5'd9, 0);
        do_op("mul_ff", 3'd0, '1, '1, 5'd1, 0);
        do_op("mulh_ff", 3'd1, '1, '1, 5'd2, 0);
        do_op("mulhsu_ff", 3'd2, '1, '1, 5'd3, 0);
        do_op("mulhu_ff", 3'd3, '1, '1, 5'd4, 0);
        do_op("div_m7_2", 3'd4, -32'sd7, 32'd2, 5'd5, 0);
        do_op("rem_m7_2", 3'd6, -32'sd7, 32'd2, 5'd6, 0);
        do_op("divu", 3'd5, 32'd100, 32'd7, 5'd7, 0);
        do_op("remu", 3'd7, 32'd100, 32'd7, 5'd8, 0);
        do_op("div0", 3'd4, 32'd5, 32'd0, 5'd10, 0);
        do_op("remu0", 3'd7, 32'd5, 32'd0, 5'd11, 0);
        do_op("div_ovf", 3'd4, MIN, '1, 5'd12, 0);
        do_op("rem_ovf", 3'd6, MIN, '1, 5'd13, 0);
        do_op("bp", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 5);
        do_op("bp_next", 3'd0, 32'd3, 32'd7, 5'd15, 0);

        // Flush mid-divide.
        req_valid = 1'b1;
        op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_val", 32'(resp_valid), 32'd0);
        chk("fl_rdy", 32'(req_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("fl_noresp", 32'(seen), 32'd0);
        do_op("fl_mul", 3'd0, 32'd12345, 32'd678, 5'd21, 0);

        // Requests are dropped while flush is high.
        flush = 1'b1;
        req_valid = 1'b1;
        op = 3'd0;
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        chk("fl_ign", 32'(busy), 32'd0);

        // A handshake coincident with flush is not a delivery.
        req_valid = 1'b1;
        op = 3'd5; rs1 = 32'd5; rs2 = 32'd0; rd = 5'd22;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("flh_val0", 32'(resp_valid), 32'd1);
        flush = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        resp_ready = 1'b0;
        chk("flh_val", 32'(resp_valid), 32'd0);
        chk("flh_busy", 32'(busy), 32'd0);

        // Reset in the middle of a multiply.
        req_valid = 1'b1;
        op = 3'd0; rs1 = 32'd3; rs2 = 32'd5; rd = 5'd23;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rm_busy0", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rm_val", 32'(resp_valid), 32'd0);
        chk("rm_res", result, 32'd0);
        chk("rm_rd", 32'(rd_out), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rm_rdy", 32'(req_ready), 32'd1);

        for (int n = 0; n < 150; n++) begin
            do_op("rnd", 3'($urandom_range(0, 7)), pick(), pick(),
                  5'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
